// File: rtl/vector_interp_sequencer.sv
// vector_interp_sequencer
// Walks one image row through the vector ALU to upscale it horizontally.
// Source pixels are read one at a time. Each consecutive pair (p_i, p_i+1)
// is presented to the ALU as lanes 0/1 of alu_a_o. The registered 128-bit
// result is then written to destination memory with a lane mask.
// Mode 0 interpolates 3x (op 110) and mode 1 duplicates 2x (op 100).
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               command strobe, only honoured in IDLE
//   mode_i                0 = interpolate (3x), 1 = duplicate (2x)
//   src_base_i            first source pixel address
//   dst_base_i            first destination pixel address
//   row_len_i             source pixel count N
//   busy_o                high whenever the sequencer is not IDLE
//   done_o                one-cycle pulse at the end of a command
//   err_o                 set when a command with N<2 is accepted
//   rd_en_o, rd_addr_o    pixel read request (data returns next cycle)
//   rd_data_i             pixel read data
//   alu_vcsub_o           tied low
//   alu_op_o              ALU opcode
//   alu_a_o, alu_b_o      ALU operands (b tied low)
//   alu_out_i             ALU result, combinational
//   wr_en_o, wr_ready_i   destination write handshake
//   wr_addr_o             destination address of lane 0
//   wr_data_o             registered lane data
//   wr_mask_o             lane enables, bit k = lane k
module vector_interp_sequencer #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [LEN_W-1:0]  row_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [31:0]       rd_data_i,
    output logic              alu_vcsub_o,
    output logic [2:0]        alu_op_o,
    output logic [127:0]      alu_a_o,
    output logic [127:0]      alu_b_o,
    input  logic [127:0]      alu_out_i,
    output logic              wr_en_o,
    input  logic              wr_ready_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [127:0]      wr_data_o,
    output logic [3:0]        wr_mask_o
);

    localparam logic [2:0] ALU_OP_INTERP = 3'b110;
    localparam logic [2:0] ALU_OP_DUP    = 3'b100;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_FIRST  = 3'd1,
        CAP_FIRST = 3'd2,
        RD_NEXT   = 3'd3,
        CAP_NEXT  = 3'd4,
        WRITE     = 3'd5,
        FINISH    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [ADDR_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   i_q, i_d;
    logic [31:0]        p_prev_q, p_prev_d;
    logic [31:0]        p_cur_q, p_cur_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [127:0]       wr_data_q, wr_data_d;
    logic [3:0]         wr_mask_q, wr_mask_d;
    logic               err_q, err_d;

    logic [ADDR_W-1:0]  i_addr_s;
    logic [ADDR_W-1:0]  step_off_s;
    logic               last_pair_s;

    // Pair index in address width; STEP*i is formed by shift-and-add.
    assign i_addr_s    = ADDR_W'(i_q);
    assign step_off_s  = mode_q ? (i_addr_s << 1) : ((i_addr_s << 1) + i_addr_s);
    // N>=2 is guaranteed once we leave IDLE, so N-2 never underflows here.
    assign last_pair_s = (i_q == (len_q - LEN_W'(2)));

    // Next-state and datapath register updates
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        i_d       = i_q;
        p_prev_d  = p_prev_q;
        p_cur_d   = p_cur_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (row_len_i < LEN_W'(2)) begin
                        // Nothing to pair up: flag it and finish with no traffic.
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        mode_d  = mode_i;
                        src_d   = src_base_i;
                        dst_d   = dst_base_i;
                        len_d   = row_len_i;
                        i_d     = {LEN_W{1'b0}};
                        state_d = RD_FIRST;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_FIRST:  state_d = CAP_FIRST;
            CAP_FIRST: begin
                p_prev_d = rd_data_i;
                state_d  = RD_NEXT;
            end
            RD_NEXT:   state_d = CAP_NEXT;
            CAP_NEXT: begin
                wr_data_d = alu_out_i;
                p_cur_d   = rd_data_i;
                wr_addr_d = dst_q + step_off_s;
                // The last pair also owns the final pixel, so lane 3 is kept.
                if (last_pair_s) begin
                    wr_mask_d = 4'b1111;
                end else begin
                    wr_mask_d = mode_q ? 4'b0011 : 4'b0111;
                end
                state_d = WRITE;
            end
            WRITE: begin
                if (wr_ready_i) begin
                    p_prev_d = p_cur_q;
                    i_d      = i_q + LEN_W'(1);
                    state_d  = last_pair_s ? FINISH : RD_NEXT;
                end else begin
                    state_d = WRITE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            src_q     <= {ADDR_W{1'b0}};
            dst_q     <= {ADDR_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            i_q       <= {LEN_W{1'b0}};
            p_prev_q  <= 32'd0;
            p_cur_q   <= 32'd0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= 128'd0;
            wr_mask_q <= 4'b0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            i_q       <= i_d;
            p_prev_q  <= p_prev_d;
            p_cur_q   <= p_cur_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            err_q     <= err_d;
        end
    end

    // Moore output decode from the state register
    always_comb begin
        busy_o    = 1'b1;
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = {ADDR_W{1'b0}};
        wr_en_o   = 1'b0;
        alu_op_o  = mode_q ? ALU_OP_DUP : ALU_OP_INTERP;
        alu_a_o   = 128'd0;
        case (state_q)
            IDLE: begin
                busy_o   = 1'b0;
                alu_op_o = 3'b000;
            end
            RD_FIRST: begin
                rd_en_o   = 1'b1;
                rd_addr_o = src_q;
            end
            RD_NEXT: begin
                rd_en_o   = 1'b1;
                rd_addr_o = src_q + i_addr_s + ADDR_W'(1);
            end
            // Operands are only meaningful while the new pixel is on rd_data_i.
            CAP_NEXT: alu_a_o = {64'd0, rd_data_i, p_prev_q};
            WRITE:    wr_en_o = 1'b1;
            FINISH: begin
                done_o   = 1'b1;
                alu_op_o = 3'b000;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign err_o       = err_q;
    assign alu_vcsub_o = 1'b0;
    assign alu_b_o     = 128'd0;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign wr_mask_o   = wr_mask_q;

endmodule

// File: doc/vector_interp_sequencer.md
Name: vector_interp_sequencer

Overview:
- Sequences one image row through the vector ALU to upscale it horizontally.
- Reads 32-bit source pixels one at a time from pixel memory and presents consecutive pixel pairs to the ALU.
- Selects either the interpolate op (3'b110) or the duplicate op (3'b100), then writes the 128-bit lane result to destination memory with a lane mask.
- Sits between the row-level control unit (start/done) and the vector ALU plus data memory.

Parameters:
ADDR_W, 16, pixel (32-bit word) address width
LEN_W, 16, row length counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  command strobe, sampled only in IDLE
mode  in  1  0 = interpolate (3x), 1 = duplicate (2x); latched at start
src_base  in  ADDR_W  first source pixel address, latched at start
dst_base  in  ADDR_W  first destination pixel address, latched at start
row_len  in  LEN_W  number of source pixels N, latched at start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of command
err  out  1  set at start if N<2, cleared by next accepted start
rd_en  out  1  read strobe
rd_addr  out  ADDR_W  read address
rd_data  in  32  read data, valid exactly one cycle after rd_en
alu_vcsub  out  1  tied 0
alu_op  out  3  110 (mode 0) or 100 (mode 1)
alu_a  out  128  {64'b0, rd_data, p_prev}
alu_b  out  128  tied 0
alu_out  in  128  vector ALU result (combinational)
wr_en  out  1  write request
wr_ready  in  1  memory accepts write when wr_en & wr_ready
wr_addr  out  ADDR_W  destination address of lane 0
wr_data  out  128  registered ALU result
wr_mask  out  4  lane enables, bit k = lane k

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0. Reset mid-command aborts immediately, with no done pulse and no further reads or writes.
- State IDLE:
  - start=1 with N>=2: latch inputs, pair index i=0, err=0, go to RD_FIRST.
  - start=1 with N<2: err=1, go to FINISH with no memory traffic.
- State RD_FIRST: rd_en=1, rd_addr=src_base. Go to CAP_FIRST.
- State CAP_FIRST: p_prev<=rd_data. Go to RD_NEXT.
- State RD_NEXT: rd_en=1, rd_addr=src_base+i+1. Go to CAP_NEXT.
- State CAP_NEXT: alu_a lane1 = rd_data. Register:
  - wr_data<=alu_out
  - p_cur<=rd_data
  - wr_addr<=dst_base+STEP*i, where STEP=3 (mode 0) or 2 (mode 1)
  - wr_mask<=1111 if i==N-2, else 0111 (mode 0) / 0011 (mode 1)
  - Go to WRITE.
- State WRITE: wr_en=1. wr_addr, wr_data and wr_mask are held stable while wr_ready=0. On handshake:
  - p_prev<=p_cur, i<=i+1
  - If i==N-2, go to FINISH; else go to RD_NEXT.
- State FINISH: done=1 for one cycle, then IDLE. busy drops the same cycle done is seen low.
- start in any state other than IDLE is ignored.
- Each source pixel is read exactly once. Total reads = N.
- Total writes = N-1. Total destination pixels = STEP*(N-1)+1.
- Lane contents in mode 0: p_i, (2p_i+p_{i+1})/3, (2p_{i+1}+p_i)/3, p_{i+1}. Unsigned truncating divide, done by the ALU.
- Lane contents in mode 1: p_i, p_i, p_{i+1}, p_{i+1}.
- Address arithmetic wraps modulo 2^ADDR_W.
- Timing with wr_ready=1 (start accepted at cycle 0):
  - RD_FIRST at cycle 1, first wr_en at cycle 5.
  - One pair per 3 cycles thereafter.
  - done at cycle 3N. For N=2, done at cycle 6.

Test Plan:
- Mode 0, N=2, src[0]=30, src[1]=60, dst_base=0x100, wr_ready=1 -> one write at cycle 5: addr 0x100, mask 1111, lanes {60,50,40,30} (lane3..0); done at cycle 6; exactly 2 reads.
- Mode 0, N=4, pixels 0,30,60,90, dst_base=0 -> writes at addr 0 (mask 0111, lanes 0,10,20), addr 3 (0111, 30,40,50), addr 6 (1111, 60,70,80,90); done at cycle 12.
- Mode 1, N=3, pixels 5,7,9, dst_base=0x20 -> writes at 0x20 (mask 0011, lanes 5,5) and 0x22 (mask 1111, lanes 7,7,9,9).
- Mode 0, N=3, wr_ready held low for 4 cycles during the first write -> wr_en, addr, data and mask stable throughout; no extra reads; correct results after release; done delayed by 4 cycles.
- row_len=1 and row_len=0 -> err=1, no rd_en/wr_en, done pulse one cycle after FINISH entry; a second start with N=2 clears err.
- rst asserted during WRITE of an N=4 run -> next cycle all outputs 0, no done; start pulsed while busy is ignored; a fresh start after reset completes normally.
